// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer that shares one UART transmitter between NREQ byte requesters.
// Optional macro UART_TX_ARB_PRIO_EN switches selection to fixed lowest-index priority.
module uart_tx_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_odd,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   tx_done,
  output logic              busy,
  output logic              TBRE,
  output logic              ld_tbr,
  output logic [7:0]        datain,
  output logic              PRT,
  output logic              TxEn,
  input  logic              setTBRE,
  input  logic              setTC
);

  localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);
  localparam logic [IdW-1:0]  IdMax  = IdW'(NREQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitStart,
    StWaitDone
  } state_e;

  state_e          state_q;
  logic            tbre_q;
  logic            prt_q;
  logic [7:0]      datain_q;
  logic [IdW-1:0]  rr_q;
  logic [IdW-1:0]  cur_id_q;
  logic [CntW-1:0] cnt_q;

  logic [7:0]      req_bytes [NREQ];
  logic [IdW-1:0]  pick;
  logic            pick_valid;
  logic            load_fire;
  logic [IdW-1:0]  rr_next;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // Scan downwards so the candidate closest to the search start wins.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef UART_TX_ARB_PRIO_EN
      idx = 32'(k);
`else
      idx = (32'(rr_q) + 32'(k)) % NREQ;
`endif
      if (req[idx[IdW-1:0]]) begin
        pick       = idx[IdW-1:0];
        pick_valid = 1'b1;
      end
    end
  end

`ifdef UART_TX_ARB_PRIO_EN
  // The pointer keeps advancing in priority mode but nothing reads it.
  logic unused_rr;
  assign unused_rr = ^rr_q;
`endif

  assign load_fire = (state_q == StLoad) && req[cur_id_q];
  assign rr_next   = (cur_id_q == IdMax) ? '0 : cur_id_q + 1'b1;
  assign cnt_inc   = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      tbre_q   <= 1'b1;
      prt_q    <= 1'b0;
      datain_q <= 8'h00;
      rr_q     <= '0;
      cur_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      // A load in the same cycle as setTBRE leaves the buffer full.
      if (load_fire) begin
        tbre_q <= 1'b0;
      end else if (setTBRE) begin
        tbre_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (tbre_q && pick_valid) begin
            cur_id_q <= pick;
            datain_q <= req_bytes[pick];
            prt_q    <= req_odd[pick];
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          cnt_q   <= '0;
          state_q <= load_fire ? StWaitStart : StIdle;
        end
        StWaitStart: begin
          cnt_q <= cnt_inc;
          if (setTBRE) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (setTC) begin
            cnt_q   <= '0;
            rr_q    <= rr_next;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    gnt               = '0;
    tx_done           = '0;
    gnt[cur_id_q]     = load_fire;
    tx_done[cur_id_q] = (state_q == StWaitDone) && setTC;
  end

  assign ld_tbr = load_fire;
  assign busy   = (state_q != StIdle);
  assign TBRE   = tbre_q;
  assign datain = datain_q;
  assign PRT    = prt_q;
  assign TxEn   = (cnt_q == CntMax);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter; a second instance runs with BAUD_DIV=2.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int B  = 4;
  localparam int B2 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_odd = '0;
  logic        setTBRE = 1'b0;
  logic        setTC = 1'b0;

  logic [3:0] gnt, tx_done;
  logic       busy, TBRE, ld_tbr, PRT, TxEn;
  logic [7:0] datain;
  logic [3:0] gnt2, tx_done2;
  logic       busy2, TBRE2, ld_tbr2, PRT2, TxEn2;
  logic [7:0] datain2;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(N), .BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_odd(req_odd),
    .gnt(gnt), .tx_done(tx_done), .busy(busy), .TBRE(TBRE), .ld_tbr(ld_tbr),
    .datain(datain), .PRT(PRT), .TxEn(TxEn), .setTBRE(setTBRE), .setTC(setTC)
  );

  uart_tx_arbiter #(.NREQ(N), .BAUD_DIV(B2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_odd(req_odd),
    .gnt(gnt2), .tx_done(tx_done2), .busy(busy2), .TBRE(TBRE2), .ld_tbr(ld_tbr2),
    .datain(datain2), .PRT(PRT2), .TxEn(TxEn2), .setTBRE(setTBRE), .setTC(setTC)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         rr_m = 0;
  logic [7:0] data_m [N];
  logic       odd_m [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected winner straight from the arbitration rule.
  function automatic int pick_m(input logic [3:0] p, input int rr);
`ifdef UART_TX_ARB_PRIO_EN
    for (int i = 0; i < N; i++) if (p[i]) return i;
`else
    for (int k = 0; k < N; k++) if (p[(rr + k) % N]) return (rr + k) % N;
`endif
    return -1;
  endfunction

  task automatic apply_data();
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = data_m[i];
      req_odd[i]         = odd_m[i];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // k counts cycles since entering WAIT_START; a tick lands on every DIV-th cycle.
  task automatic chk_wait(input string tag, input int k);
    check({tag, "_txen"},  32'(TxEn),  32'((k % B) == (B - 1)));
    check({tag, "_txen2"}, 32'(TxEn2), 32'((k % B2) == (B2 - 1)));
    check({tag, "_busy"},  32'(busy),  1);
    check({tag, "_gnt"},   32'(gnt),   0);
    check({tag, "_ld"},    32'(ld_tbr), 0);
  endtask

  // Entered at posedge+1 of an IDLE cycle with a nonzero req already driven.
  task automatic run_frame(input bit stray_tc, input bit rearm);
    int id;
    int k;
    int n1;
    int n2;
    id = pick_m(req, rr_m);
    settle();
    check("idle_busy", 32'(busy), 0);
    check("idle_txen", 32'(TxEn), 0);
    check("idle_gnt",  32'(gnt), 0);
    check("idle_tbre", 32'(TBRE), 1);
    cyc();
    settle();
    check("load_gnt",    32'(gnt), 32'(1 << id));
    check("load_ld",     32'(ld_tbr), 1);
    check("load_datain", 32'(datain), 32'(data_m[id]));
    check("load_prt",    32'(PRT), 32'(odd_m[id]));
    check("load_tbre",   32'(TBRE), 1);
    check("load_txen",   32'(TxEn | TxEn2), 0);
    cyc();
    req[id] = 1'b0;
    settle();
    k = 0;
    check("ws_tbre",   32'(TBRE), 0);
    check("ws_datain", 32'(datain), 32'(data_m[id]));
    chk_wait("ws", k);
    n1 = $urandom_range(0, 6);
    for (int j = 0; j < n1; j++) begin
      setTC = stray_tc;
      settle();
      check("ws_stray_done", 32'(tx_done), 0);
      cyc();
      setTC = 1'b0;
      k++;
      settle();
      check("ws_hold_tbre", 32'(TBRE), 0);
      chk_wait("ws_hold", k);
    end
    setTBRE = 1'b1;
    settle();
    check("ws_settbre_tbre", 32'(TBRE), 0);
    cyc();
    setTBRE = 1'b0;
    k++;
    settle();
    check("wd_tbre", 32'(TBRE), 1);
    chk_wait("wd", k);
    n2 = $urandom_range(0, 9);
    for (int j = 0; j < n2; j++) begin
      cyc();
      k++;
      settle();
      check("wd_hold_done", 32'(tx_done), 0);
      chk_wait("wd_hold", k);
    end
    setTC = 1'b1;
    settle();
    check("wd_tx_done", 32'(tx_done), 32'(1 << id));
    rr_m = (id + 1) % N;
    if (rearm) begin
      data_m[id] = 8'($urandom);
      odd_m[id]  = 1'($urandom);
      apply_data();
      req[id] = 1'b1;
    end
    cyc();
    setTC = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      data_m[i] = 8'($urandom);
      odd_m[i]  = 1'($urandom);
    end
    apply_data();
    #12;
    check("rst_tbre",   32'(TBRE), 1);
    check("rst_busy",   32'(busy), 0);
    check("rst_gnt",    32'(gnt), 0);
    check("rst_ld",     32'(ld_tbr), 0);
    check("rst_done",   32'(tx_done), 0);
    check("rst_datain", 32'(datain), 0);
    check("rst_prt",    32'(PRT), 0);
    check("rst_txen",   32'(TxEn | TxEn2), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Single requester, known byte.
    data_m[0] = 8'hA5;
    odd_m[0]  = 1'b1;
    apply_data();
    req = 4'b0001;
    run_frame(1'b0, 1'b0);
    settle();
    check("t1_after_busy", 32'(busy), 0);
    check("t1_after_tbre", 32'(TBRE), 1);
    check("t1_after_done", 32'(tx_done), 0);

    // All requesters held and re-raised after each grant.
    req = 4'b1111;
    for (int f = 0; f < 5; f++) run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);
    req = 4'b0000;

    // Stray setTC while idle.
    setTC = 1'b1;
    settle();
    check("idle_stray_done", 32'(tx_done), 0);
    cyc();
    setTC = 1'b0;
    settle();
    check("idle_stray_busy", 32'(busy), 0);

    // Withdrawal in the LOAD cycle.
    req = 4'b0100;
    cyc();
    req = 4'b0000;
    settle();
    check("wd_load_gnt",  32'(gnt), 0);
    check("wd_load_ld",   32'(ld_tbr), 0);
    check("wd_load_busy", 32'(busy), 1);
    check("wd_load_tbre", 32'(TBRE), 1);
    cyc();
    settle();
    check("wd_idle_busy", 32'(busy), 0);
    check("wd_idle_tbre", 32'(TBRE), 1);
    req = 4'b1111;
    run_frame(1'b0, 1'b0);
    req = 4'b0000;

    // Reset while waiting for frame completion, right on a baud tick.
    req = 4'b0010;
    cyc();
    cyc();
    req = 4'b0000;
    setTBRE = 1'b1;
    cyc();
    setTBRE = 1'b0;
    cyc();
    cyc();
    settle();
    check("pre_rst_txen",  32'(TxEn), 1);
    check("pre_rst_txen2", 32'(TxEn2), 1);
    rst = 1'b0;
    settle();
    check("mid_rst_tbre",   32'(TBRE), 1);
    check("mid_rst_busy",   32'(busy), 0);
    check("mid_rst_txen",   32'(TxEn | TxEn2), 0);
    check("mid_rst_datain", 32'(datain), 0);
    rr_m = 0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    req = 4'b0100;
    run_frame(1'b0, 1'b0);

    // Randomized traffic; pending requests stay held until granted.
    for (int f = 0; f < 25; f++) begin
      logic [3:0] add;
      add = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if (add[i] && !req[i]) begin
          data_m[i] = 8'($urandom);
          odd_m[i]  = 1'($urandom);
        end
      end
      apply_data();
      req = req | add;
      if (req == 4'b0000) req = 4'b1000;
      run_frame(1'($urandom_range(0, 1)), 1'b0);
    end
    req = 4'b0000;
    settle();
    check("end_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Sequencer and arbiter that shares the UART transmitter between NREQ byte requesters.
- Owns the transmitter's TBRE flag, ld_tbr strobe, datain bus, PRT parity select and TxEn baud tick.
- Grants one requester per frame, round-robin. The next grant is issued only after the transmitter reports frame complete (setTC).
- Sits between the client blocks and the transmitter; the transmitter never sees more than one owner.

Parameters:
NREQ, 4, number of requesters (2..8)
BAUD_DIV, 16, clk cycles per TxEn tick (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
req  in  NREQ  per-requester "byte pending"; held high until gnt
req_data  in  8*NREQ  byte of requester i at [8i+7:8i]
req_odd  in  NREQ  per-requester PRT value for its frame
gnt  out  NREQ  one-cycle one-hot pulse: byte of requester i accepted
tx_done  out  NREQ  one-cycle one-hot pulse: requester i's frame finished (setTC seen)
busy  out  1  high in any state other than IDLE
TBRE  out  1  transmit-buffer-empty flag to transmitter
ld_tbr  out  1  load strobe to transmitter
datain  out  8  byte to transmitter
PRT  out  1  parity select to transmitter
TxEn  out  1  baud tick to transmitter
setTBRE  in  1  from transmitter: TBR moved to TSR
setTC  in  1  from transmitter: frame complete

Behaviour:
Reset (rst=0, async):
- state=IDLE, TBRE=1, rr pointer=0, cur_id=0, baud cnt=0, PRT=0.
- gnt, tx_done, ld_tbr, TxEn = 0; datain=8'h00.
- Reset mid-frame abandons the frame; the transmitter is reset by the same net.

States: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE:
  - If TBRE=1 and req!=0: select the first set req bit at or after rr (wrapping), register cur_id, go LOAD.
  - Else stay in IDLE.
- LOAD (1 cycle):
  - If req[cur_id]=1: ld_tbr=1, datain=req_data[cur_id], PRT=req_odd[cur_id], gnt[cur_id]=1. TBRE clears at this edge. Go WAIT_START.
  - If req[cur_id]=0 (withdrawn): no ld_tbr, no gnt, rr unchanged, go IDLE.
- WAIT_START:
  - On setTBRE=1: TBRE set to 1, go WAIT_DONE.
  - If setTBRE never comes, wait indefinitely; there is no timeout.
- WAIT_DONE:
  - On setTC=1: tx_done[cur_id]=1 for that cycle, rr=(cur_id+1) mod NREQ, go IDLE.
  - setTC in any other state is ignored.
- Simultaneous setTBRE and setTC in WAIT_START: take the TBRE set only; setTC is lost. This is legal only because the transmitter never produces it.

Outputs and flags:
- datain and PRT are registered at the LOAD edge and held until the next LOAD.
- Only ld_tbr and gnt are combinational from state and req.
- TBRE write priority: the clear in LOAD wins over setTBRE in the same cycle.

Baud tick:
- cnt is forced to 0 in IDLE and LOAD.
- In WAIT_START and WAIT_DONE, cnt increments and wraps at BAUD_DIV-1.
- TxEn=1 exactly when cnt==BAUD_DIV-1, so the first tick comes BAUD_DIV cycles after entering WAIT_START.

Latency:
- req rise in IDLE to gnt: 1 cycle.
- Back-to-back frames: IDLE lasts 1 cycle between setTC and the next LOAD.

Optional Feature:
UART_TX_ARB_PRIO_EN
- Defined: fixed priority; the lowest-index pending req wins, and rr is ignored (still updated).
- Undefined: round-robin as above.

Test Plan:
1. NREQ=4, BAUD_DIV=4. req=4'b0001, data0=8'hA5, odd0=1 → gnt=0001 one cycle after req; ld_tbr=1, datain=A5, PRT=1 in that cycle; TBRE 1→0→1 around setTBRE; TxEn every 4 cycles; tx_done=0001 on setTC; busy low after.
2. req=4'b1111 held, each requester re-asserting after its gnt → grant order 0,1,2,3,0. Never a second gnt before the prior tx_done. With UART_TX_ARB_PRIO_EN: order 0,0,0…
3. Withdrawal: raise req[2] alone, drop it in the LOAD cycle → no gnt, no ld_tbr, TBRE stays 1, state IDLE next cycle, rr unchanged.
4. Reset mid-frame: assert rst=0 during WAIT_DONE → TBRE=1, busy=0, TxEn=0 immediately. After release, req=4'b0100 is granted to requester 2 (rr=0, first set bit).
5. Stray setTC pulse in IDLE and in WAIT_START → ignored, no tx_done, no state change.
6. BAUD_DIV=2 → TxEn toggles every other cycle; it is 0 throughout IDLE and LOAD.
